operand_unpack: RTL and testbench
=================================

# operand_unpack

Two-stage pipelined IEEE-754 single-precision operand unpacker at the FPU input side, the counterpart of the result packer. Accepts a pair of 32-bit operands through a valid/ready handshake and splits each into sign, exponent and mantissa fields. Classifies each operand with the 2-bit flag code the packer consumes. Denormals are flushed to signed zero and counted in a saturating status counter.

## Interface
- No parameters; widths fixed to single precision (1/8/23).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a, b  in  32  raw operands, sampled when in_valid && in_ready.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- sa, sb  out  1  operand signs.
- ea, eb  out  8  biased exponents.
- ma, mb  out  23  fractions, hidden bit excluded.
- fa, fb  out  2  class flags: 00 infinity, 01 NaN, 10 zero, 11 normal.
- out_valid  out  1  unpacked pair valid.
- out_ready  in  1  downstream consumes pair when out_valid && out_ready.
- dnz_cnt  out  8  saturating count of operands flushed from denormal to zero.

## Operation
- Stage 1 (capture): registers a, b and valid bit v1 on an input handshake.
- Stage 2 (classify/output): registers sign, exponent, fraction, flag for both operands and v2 (= out_valid).
- Per operand, with E = bits[30:23], M = bits[22:0]:
  - E = FF, M = 0: flag 00, e = FF, m = 0.
  - E = FF, M ≠ 0: flag 01, e = FF, m = M unchanged (payload kept).
  - E = 00, M = 0: flag 10, e = 0, m = 0.
  - E = 00, M ≠ 0: flag 10, e = 0, m = 0 (flushed). dnz_cnt increments.
  - Otherwise: flag 11, e = E, m = M.
  - Sign always passed unchanged, including for NaN and zero.
- dnz_cnt increments by 0, 1 or 2 (a and b both denormal) when a pair moves from stage 1 into stage 2. It saturates at 255 and never wraps. Only reset clears it.
- Flow control (full-throughput, no bubbles):
  - stage2 advances when !v2 || out_ready.
  - stage1 advances into stage2 when v1 && stage2 advances.
  - in_ready = !v1 || stage2 advances (combinational from out_ready and state).
- Stall: while out_valid && !out_ready, all stage 2 outputs hold stable. Stage 1 holds its pair. in_ready drops once stage 1 is occupied.
- No combinational path from a/b to outputs. out_valid is registered.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): v1 = v2 = 0, out_valid = 0, in_ready = 1, all s/e/m = 0, fa = fb = 00, dnz_cnt = 0, captured operands = 0.
- Reset mid-operation discards both in-flight pairs. No output handshake occurs for them.
- Latency: a pair accepted at edge N appears with out_valid = 1 after edge N+1 (2 register stages), provided out_ready was 1.
- Throughput: 1 pair/cycle with out_ready held high.
- Simultaneous accept and consume: with both stages full and out_ready = 1, in_ready = 1. Stage 2 loads stage 1's pair, stage 1 loads the new pair, and there is no loss or duplication.
- Full: both stages full and out_ready = 0 gives in_ready = 0. Inputs are ignored while in_valid is high.
- Empty: out_valid = 0. Output data values are don't-care but are held at their last value, not cleared.
- dnz_cnt updates on the same edge the pair enters stage 2, and is visible one edge before that pair's out_valid is consumed.

## Test plan
- Reset then single pair a = 3F800000, b = C0000000, out_ready = 1 -> two edges later out_valid = 1, sa = 0 ea = 7F ma = 0 fa = 11, sb = 1 eb = 80 mb = 0 fb = 11, dnz_cnt = 0.
- Specials: a = 7F800000, b = FFC00001 -> fa = 00 ea = FF ma = 0. fb = 01 sb = 1 eb = FF mb = 400001. Next pair a = 80000000, b = 00000001 -> fa = 10 sa = 1, fb = 10 mb = 0, dnz_cnt = 1.
- Back-pressure: stream 4 pairs with out_ready = 0 -> stages fill after 2 accepts, in_ready = 0, outputs stable. Release out_ready -> the 4 pairs emerge in order with no drop or duplicate.
- Continuous throughput: 100 random pairs, in_valid = out_ready = 1 -> one output per cycle after 2-cycle latency, every field matches the reference model.
- Saturation: 130 pairs with both operands denormal -> dnz_cnt = 255 and held, no wrap.
- Async reset asserted mid-stream with both stages full -> out_valid falls immediately, in_ready = 1, dnz_cnt = 0. The first post-reset pair emerges correctly after 2 edges.

Source files
------------

// File: rtl/operand_unpack.sv
// operand_unpack: two-stage IEEE-754 single-precision operand unpacker.
// Captures an operand pair on a valid/ready handshake, then splits each
// operand into sign/exponent/fraction plus a 2-bit class flag for the FPU.
// Denormals are flushed to signed zero and tallied in a saturating counter.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   a, b              raw 32-bit operands (sampled on in_valid && in_ready)
//   in_valid/in_ready upstream handshake
//   sa/sb, ea/eb      operand signs, biased exponents
//   ma/mb             fractions without hidden bit
//   fa/fb             class flags: 00 inf, 01 NaN, 10 zero, 11 normal
//   out_valid/out_ready downstream handshake
//   dnz_cnt           saturating count of flushed denormal operands
module operand_unpack (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sa,
    output logic        sb,
    output logic [7:0]  ea,
    output logic [7:0]  eb,
    output logic [22:0] ma,
    output logic [22:0] mb,
    output logic [1:0]  fa,
    output logic [1:0]  fb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  dnz_cnt
);

    localparam int unsigned OP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned FLAG_W = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [FLAG_W-1:0] FLAG_INF  = 2'b00;
    localparam logic [FLAG_W-1:0] FLAG_NAN  = 2'b01;
    localparam logic [FLAG_W-1:0] FLAG_ZERO = 2'b10;
    localparam logic [FLAG_W-1:0] FLAG_NORM = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic [FLAG_W-1:0] flag;
        logic              dnz;
    } unpacked_t;

    // Split and classify one operand; denormals collapse to signed zero.
    function automatic unpacked_t classify(input logic [OP_W-1:0] op);
        unpacked_t         r;
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] m;
        e = op[OP_W-2:FRAC_W];
        m = op[FRAC_W-1:0];
        r.sign = op[OP_W-1];
        r.exp  = e;
        r.frac = m;
        r.flag = FLAG_NORM;
        r.dnz  = 1'b0;
        if (&e) begin
            // NaN payload is kept; for infinity m is already zero.
            r.flag = (|m) ? FLAG_NAN : FLAG_INF;
        end else if (~|e) begin
            r.frac = '0;
            r.flag = FLAG_ZERO;
            r.dnz  = |m;
        end
        return r;
    endfunction

    logic            v1;
    logic [OP_W-1:0] a_q;
    logic [OP_W-1:0] b_q;

    logic adv2_c;
    logic adv1_c;
    logic take_c;

    unpacked_t               ua_c;
    unpacked_t               ub_c;
    logic [1:0]              dnz_inc_c;
    logic [CNT_W:0]          dnz_sum_c;
    logic [CNT_W-1:0]        dnz_next_c;

    // Handshake: stage 2 drains or is empty; stage 1 refills as it empties.
    assign adv2_c   = !out_valid || out_ready;
    assign adv1_c   = v1 && adv2_c;
    assign in_ready = !v1 || adv2_c;
    assign take_c   = in_valid && in_ready;

    // Classification of the captured pair and the saturating counter update.
    always_comb begin
        ua_c       = classify(a_q);
        ub_c       = classify(b_q);
        dnz_inc_c  = 2'(ua_c.dnz) + 2'(ub_c.dnz);
        dnz_sum_c  = (CNT_W+1)'(dnz_cnt) + (CNT_W+1)'(dnz_inc_c);
        dnz_next_c = dnz_sum_c[CNT_W] ? CNT_MAX : dnz_sum_c[CNT_W-1:0];
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (in_ready) begin
                v1 <= in_valid;
            end
            if (take_c) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    // Stage 2: unpacked fields; data holds when empty or stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            ea        <= '0;
            eb        <= '0;
            ma        <= '0;
            mb        <= '0;
            fa        <= FLAG_INF;
            fb        <= FLAG_INF;
            dnz_cnt   <= '0;
        end else begin
            if (adv2_c) begin
                out_valid <= v1;
            end
            if (adv1_c) begin
                sa      <= ua_c.sign;
                ea      <= ua_c.exp;
                ma      <= ua_c.frac;
                fa      <= ua_c.flag;
                sb      <= ub_c.sign;
                eb      <= ub_c.exp;
                mb      <= ub_c.frac;
                fb      <= ub_c.flag;
                dnz_cnt <= dnz_next_c;
            end
        end
    end

endmodule

// File: tb/tb_operand_unpack.sv
// Self-checking bench for operand_unpack: directed cases from the plan plus
// randomized streams compared against a behavioural queue model.
module tb_operand_unpack;

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic        in_valid, in_ready;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic [1:0]  fa, fb;
    logic        out_valid, out_ready;
    logic [7:0]  dnz_cnt;

    operand_unpack dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .sa(sa), .sb(sb), .ea(ea), .eb(eb), .ma(ma), .mb(mb), .fa(fa), .fb(fb),
        .out_valid(out_valid), .out_ready(out_ready), .dnz_cnt(dnz_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          dnz;
    } pair_t;

    pair_t q[$];
    int    passed = 0;
    int    total  = 0;
    int    cum    = 0;
    int    popped = 0;
    int    cyc    = 0;

    logic         prev_stall = 1'b0;
    logic [127:0] prev_out   = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: {sign, exp, frac, flag} from the IEEE field rules.
    function automatic logic [33:0] model(input logic [31:0] x);
        int          ex;
        int          fr;
        logic [7:0]  e;
        logic [22:0] m;
        logic [1:0]  f;
        ex = int'(x[30:23]);
        fr = int'(x[22:0]);
        if (ex == 255) begin
            e = 8'd255; m = x[22:0]; f = (fr == 0) ? 2'd0 : 2'd1;
        end else if (ex == 0) begin
            e = 8'd0; m = 23'd0; f = 2'd2;
        end else begin
            e = x[30:23]; m = x[22:0]; f = 2'd3;
        end
        return {x[31], e, m, f};
    endfunction

    function automatic int is_dnz(input logic [31:0] x);
        return (x[30:23] == 8'd0 && x[22:0] != 23'd0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [22:0] fr;
        s  = 1'($urandom);
        fr = 23'($urandom_range(1, 23'h7FFFFF));
        case ($urandom_range(0, 4))
            0:       return {s, 8'hFF, 23'd0};
            1:       return {s, 8'hFF, fr};
            2:       return {s, 8'h00, 23'd0};
            3:       return {s, 8'h00, fr};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // Monitor: scoreboard compare, stall stability, and input capture.
    always @(negedge clk) begin
        logic [127:0] cur;
        pair_t        p;
        if (rst) begin
            q.delete();
            cum        = 0;
            prev_stall = 1'b0;
        end else begin
            cur = 128'({out_valid, sa, ea, ma, fa, sb, eb, mb, fb, dnz_cnt});
            if (prev_stall) chk("stall_hold", cur, prev_out);
            if (out_valid) begin
                chk("out_has_pending", 128'(q.size() != 0), 128'(1));
                if (q.size() != 0) begin
                    chk("out_a", 128'({sa, ea, ma, fa}), 128'(model(q[0].a)));
                    chk("out_b", 128'({sb, eb, mb, fb}), 128'(model(q[0].b)));
                    chk("out_dnz", 128'(dnz_cnt), 128'(q[0].dnz));
                    if (out_ready) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = cur;
            if (in_valid && in_ready) begin
                cum   = cum + is_dnz(a) + is_dnz(b);
                p.a   = a;
                p.b   = b;
                p.dnz = (cum > 255) ? 255 : cum;
                q.push_back(p);
            end
        end
    end

    // Offer one pair until accepted; called and returns just after a posedge.
    task automatic push(input logic [31:0] xa, input logic [31:0] xb);
        int   n;
        logic ok;
        n = 0;
        a = xa; b = xb; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 64);
        if (!ok) chk("push_timeout", 128'(ok), 128'(1));
        in_valid = 1'b0;
    endtask

    // Single pair into an empty pipe; returns at the negedge it must be visible.
    task automatic send1(input logic [31:0] xa, input logic [31:0] xb);
        a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("latency_valid", 128'(out_valid), 128'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 128'(q.size() == 0), 128'(1));
    endtask

    initial begin
        int start;
        int p0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 128'({out_valid, in_ready, sa, ea, ma, fa, sb, eb, mb, fb, dnz_cnt}),
            128'({1'b1, 1'b0, 66'd0, 1'b0, 7'd0} >> 0) & 128'h0 | 128'({1'b0, 1'b1, 76'd0}));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed normals.
        send1(32'h3F800000, 32'hC0000000);
        chk("norm_a", 128'({sa, ea, ma, fa}), 128'({1'b0, 8'h7F, 23'd0, 2'b11}));
        chk("norm_b", 128'({sb, eb, mb, fb}), 128'({1'b1, 8'h80, 23'd0, 2'b11}));
        chk("norm_dnz", 128'(dnz_cnt), 128'(0));
        @(posedge clk); #1;

        // Directed specials.
        send1(32'h7F800000, 32'hFFC00001);
        chk("inf_a", 128'({sa, ea, ma, fa}), 128'({1'b0, 8'hFF, 23'd0, 2'b00}));
        chk("nan_b", 128'({sb, eb, mb, fb}), 128'({1'b1, 8'hFF, 23'h400001, 2'b01}));
        @(posedge clk); #1;
        send1(32'h80000000, 32'h00000001);
        chk("zero_a", 128'({sa, ea, ma, fa}), 128'({1'b1, 8'h00, 23'd0, 2'b10}));
        chk("dnz_b", 128'({sb, eb, mb, fb}), 128'({1'b0, 8'h00, 23'd0, 2'b10}));
        chk("dnz_one", 128'(dnz_cnt), 128'(1));
        @(posedge clk); #1;

        // Back-pressure: two accepts fill both stages, then in_ready drops.
        out_ready = 1'b0;
        push(32'h40000000, 32'h40400000);
        push(32'h40800000, 32'h00000010);
        a = 32'h40A00000; b = 32'h40C00000; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", 128'(in_ready), 128'(0));
            chk("full_out_valid", 128'(out_valid), 128'(1));
            a = $urandom; b = $urandom;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(32'h40A00000, 32'h40C00000);
        push(32'h40E00000, 32'hBF800000);
        drain();

        // Continuous throughput with random classes.
        start = cyc;
        p0    = popped;
        for (int i = 0; i < 100; i++) push(rand_op(), rand_op());
        chk("tput_cycles", 128'(cyc - start), 128'(100));
        repeat (2) @(posedge clk);
        #1;
        chk("tput_outputs", 128'(popped - p0), 128'(100));
        drain();

        // Saturation of the denormal counter.
        for (int i = 0; i < 130; i++)
            push({1'($urandom), 8'h00, 23'($urandom_range(1, 23'h7FFFFF))},
                 {1'($urandom), 8'h00, 23'($urandom_range(1, 23'h7FFFFF))});
        drain();
        chk("dnz_sat", 128'(dnz_cnt), 128'(255));
        for (int i = 0; i < 3; i++) push(32'h00000003, 32'h80000005);
        drain();
        chk("dnz_hold", 128'(dnz_cnt), 128'(255));

        // Async reset with both stages full.
        out_ready = 1'b0;
        push(32'h3F800000, 32'h00000001);
        push(32'h40000000, 32'h00000002);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_state", 128'({out_valid, in_ready, dnz_cnt}), 128'({1'b0, 1'b1, 8'd0}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send1(32'h40490FDB, 32'h00000000);
        chk("post_rst_a", 128'({sa, ea, ma, fa}), 128'({1'b0, 8'h80, 23'h490FDB, 2'b11}));
        chk("post_rst_b", 128'({sb, eb, mb, fb}), 128'({1'b0, 8'h00, 23'd0, 2'b10}));
        chk("post_rst_dnz", 128'(dnz_cnt), 128'(0));
        @(posedge clk); #1;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
